// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Default buffer depth and the matching width of the in-flight/credit counters.
    localparam int DEF_BUF_DEPTH = 2;
    localparam int DEF_CNT_W     = $clog2(DEF_BUF_DEPTH + 1);

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched {pc, inst} entries; clear has priority
// over push and pop issued in the same cycle.
module fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = DEF_BUF_DEPTH,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + ONE;
            else if (do_pop && !do_push) count <= count - ONE;
        end
    end

    // Entry storage, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order memory
// requests, buffers returned words and discards wrong-path responses after a
// redirect. Optional macro INST_FETCH_PERF_CNT_EN adds perf_fetched/perf_dropped.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int CW = cnt_width(BUF_DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    fetch_state_t  state_q;
    logic          run_q;
    logic [31:0]   pc_q;
    logic [CW-1:0] in_flight_q;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_used;
    logic          buf_empty;
    logic          buf_full;
    logic          accept;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign credit_used    = {1'b0, in_flight_q} + {1'b0, buf_count};
    assign imem_req_valid = run_q && (state_q == FETCH) && !buf_full && !redirect_valid
                            && (credit_used < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && (state_q == FETCH) && !redirect_valid;
    assign pop            = id_valid && id_ready;

    // Requests are issued in order from pc_q and nothing is issued during FLUSH,
    // so the oldest outstanding request sits in_flight words behind pc_q.
    assign push_entry = '{pc: pc_q - 32'(in_flight_q) * PC_STEP, inst: imem_rsp_data};

    assign id_valid    = !buf_empty;
    assign id_inst     = buf_empty ? '0 : head.inst;
    assign id_pc       = buf_empty ? '0 : head.pc;
    assign id_pc_plus4 = buf_empty ? '0 : head.pc + PC_STEP;

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    // Responses still owed to the wrong path after this edge.
    always_comb begin
        drop_next = drop_cnt_q;
        if (redirect_valid)
            drop_next = in_flight_q - CW'(imem_rsp_valid);
        else if (state_q == FLUSH && imem_rsp_valid)
            drop_next = drop_cnt_q - ONE;
    end

    // Hold the request port idle until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // Program counter: redirect target wins over sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc_q <= RESET_PC;
        else if (redirect_valid) pc_q <= {redirect_pc[31:2], 2'b00};
        else if (accept)         pc_q <= pc_q + PC_STEP;
    end

    // Outstanding request count across both fetch states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_flight_q <= '0;
        else        in_flight_q <= in_flight_q + CW'(accept) - CW'(imem_rsp_valid);
    end

    // Fetch/flush state machine with its drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_next;
            if (redirect_valid || state_q == FLUSH)
                state_q <= (drop_next != '0) ? FLUSH : FETCH;
        end
    end

`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] dropped_q;
    logic        rsp_discard;

    assign rsp_discard  = imem_rsp_valid && (state_q == FLUSH || redirect_valid);
    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;

    // Words delivered to decode and words thrown away (late responses plus cleared entries).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (pop && !redirect_valid) fetched_q <= fetched_q + 32'd1;
            dropped_q <= dropped_q + 32'(rsp_discard)
                         + (redirect_valid ? 32'(buf_count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed + randomized bench for inst_fetch against a stream-level model:
// decode must see consecutive words from the last redirect target, each
// carrying the memory image word for its address.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    inst_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef INST_FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: every address holds a distinct hashed word.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    typedef struct {
        longint      due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mq[$];
    bit          lat0, lat0_next;
    int          lat_min, lat_max;
    longint      cyc, last_due;
    logic        mq_valid;
    logic [31:0] mq_data;

    // Zero-latency mode answers the request in its own cycle; otherwise the queue answers.
    assign imem_rsp_valid = lat0 ? (imem_req_valid && imem_req_ready) : mq_valid;
    assign imem_rsp_data  = lat0 ? memf(imem_req_addr) : mq_data;

    int          total, bad;
    int          out_cnt, idle;
    logic [31:0] exp_req, exp_id;
    int unsigned fetched_m;
    bit          p_rd, p_req_stall, p_id_stall;
    logic [31:0] p_addr, p_inst, p_pc, p_pc4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mq_valid  = 1'b0;
        mq_data   = '0;
        last_due  = 0;
        out_cnt   = 0;
        idle      = 0;
        exp_req   = RESET_PC;
        exp_id    = RESET_PC;
        fetched_m = 0;
        p_rd = 0; p_req_stall = 0; p_id_stall = 0;
    endtask

    task automatic reset_checks();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_inst", id_inst, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_pc_plus4", id_pc_plus4, 0);
`ifdef INST_FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_dropped", perf_dropped, 0);
`endif
    endtask

    // One clock cycle: drive inputs at negedge, check after settling, advance the model.
    task automatic step(input bit rd_in, input logic [31:0] rpc, input bit idr, input bit rqr,
                        input bit rd_on_rsp_pop, output bit fired);
        bit     rd, acc, pop;
        longint due;
        @(negedge clk);
        cyc++;
        lat0     = lat0_next;
        mq_valid = !lat0 && (mq.size() > 0) && (mq[0].due <= cyc);
        mq_data  = mq_valid ? memf(mq[0].addr) : '0;
        rd = rd_in || (rd_on_rsp_pop && mq_valid && id_valid && idr);
        redirect_valid = rd;
        redirect_pc    = rpc;
        id_ready       = idr;
        imem_req_ready = rqr;
        #1;
        acc = imem_req_valid && imem_req_ready;
        pop = id_valid && idr;

        if (p_rd) chk("empty_after_redirect", id_valid, 0);
        if (rd) chk("req_idle_on_redirect", imem_req_valid, 0);
        if (p_req_stall && !p_rd) chk("req_addr_hold", imem_req_addr, p_addr);
        if (p_id_stall && !p_rd) begin
            chk("id_valid_hold", id_valid, 1);
            chk("id_inst_hold", id_inst, p_inst);
            chk("id_pc_hold", id_pc, p_pc);
            chk("id_pc_plus4_hold", id_pc_plus4, p_pc4);
        end
        if (acc) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req += 32'd4;
        end
        if (id_valid) begin
            chk("id_pc", id_pc, exp_id);
            chk("id_inst", id_inst, memf(exp_id));
            chk("id_pc_plus4", id_pc_plus4, exp_id + 32'd4);
        end
`ifdef INST_FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, fetched_m);
`endif

        if (acc && !lat0) begin
            due = cyc + longint'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{due: due, addr: imem_req_addr});
            out_cnt++;
        end
        if (mq_valid) begin
            void'(mq.pop_front());
            out_cnt--;
        end
        chk("outstanding_cap", (out_cnt <= DEPTH), 1);

        if (pop && !rd) begin
            exp_id += 32'd4;
            fetched_m++;
            idle = 0;
        end else begin
            idle++;
        end
        if (rd) begin
            exp_id  = {rpc[31:2], 2'b00};
            exp_req = {rpc[31:2], 2'b00};
            idle    = 0;
        end
        chk("progress_watchdog", (idle < 60), 1);

        p_rd        = rd;
        p_req_stall = imem_req_valid && !imem_req_ready;
        p_addr      = imem_req_addr;
        p_id_stall  = id_valid && !idr;
        p_inst      = id_inst;
        p_pc        = id_pc;
        p_pc4       = id_pc_plus4;
        fired       = rd;
    endtask

    initial begin
        bit          f, seen;
        logic [31:0] r_pc;
        total = 0; bad = 0; cyc = 0;
        lat0 = 1; lat0_next = 1; lat_min = 1; lat_max = 1;
        rst_n = 0;
        redirect_valid = 0; redirect_pc = '0; id_ready = 0; imem_req_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1;

        // Zero-latency memory, always ready: back-to-back words once started.
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, '0, 1, 1, 0, f);
            if (seen) chk("no_bubble", id_valid, 1);
            if (id_valid) seen = 1;
        end

        // Decode stalls for 10 cycles: credits run out, head holds, then drains in order.
        lat0_next = 0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) step(0, '0, 0, 1, 0, f);
        chk("credit_exhausted", imem_req_valid, 0);
        for (int i = 0; i < 20; i++) step(0, '0, 1, 1, 0, f);

        // Latency 3: redirect with two requests outstanding.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && out_cnt < 2; i++) step(0, '0, 1, 1, 0, f);
        chk("two_in_flight", out_cnt, 2);
        step(1, 32'h0000_0100, 1, 1, 0, f);
        for (int i = 0; i < 30; i++) step(0, '0, 1, 1, 0, f);
        chk("post_redirect_progress", (exp_id > 32'h0000_0100), 1);

        // Redirect exactly when a response arrives and the head is popped.
        lat_min = 1; lat_max = 1;
        f = 0;
        for (int i = 0; i < 40 && !f; i++) step(0, 32'h0000_0203, 1, 1, 1, f);
        chk("rsp_pop_redirect_hit", f, 1);
        for (int i = 0; i < 20; i++) step(0, '0, 1, 1, 0, f);
        chk("post_collision_progress", (exp_id > 32'h0000_0200), 1);

        // Wrap-around of the 32-bit PC.
        lat_min = 1; lat_max = 2;
        step(1, 32'hFFFF_FFFE, 1, 1, 0, f);
        for (int i = 0; i < 25; i++) step(0, '0, 1, 1, 0, f);
        chk("wrap_progress", (exp_id >= 32'd8 && exp_id < 32'h100), 1);

        // Random traffic: latency 1..4, back-pressure on both sides, random redirects.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            r_pc = $urandom;
            step(($urandom_range(19, 0) == 0), r_pc, ($urandom_range(3, 0) != 0),
                 ($urandom_range(3, 0) != 0), 0, f);
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) step(0, '0, 1, 1, 0, f);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        reset_checks();
        redirect_valid = 0; id_ready = 0; imem_req_ready = 0;
        lat0 = 1; lat0_next = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) step(0, '0, 1, 1, 0, f);
        chk("post_reset_progress", (exp_id > RESET_PC), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
